// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: ALUOp store codes,
// store FSM states and byte-enable constants.
package store_unit_pkg;

    localparam int ALUOP_W = 8;
    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t ALU_SB  = 8'h28;
    localparam aluop_t ALU_SH  = 8'h29;
    localparam aluop_t ALU_SWL = 8'h2A;
    localparam aluop_t ALU_SW  = 8'h2B;
    localparam aluop_t ALU_SWR = 8'h2E;
    localparam aluop_t ALU_SC  = 8'h38;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } st_state_e;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_B0   = 4'b0001;
    localparam logic [3:0] WEN_B1   = 4'b0010;
    localparam logic [3:0] WEN_B2   = 4'b0100;
    localparam logic [3:0] WEN_B3   = 4'b1000;
    localparam logic [3:0] WEN_LO   = 4'b0011;
    localparam logic [3:0] WEN_HI   = 4'b1100;
    localparam logic [3:0] WEN_LO3  = 4'b0111;
    localparam logic [3:0] WEN_HI3  = 4'b1110;
    localparam logic [3:0] WEN_ALL  = 4'b1111;

endpackage

// File: rtl/store_align.sv
// Combinational store lane aligner: byte enables, data and AdES.
// SWL/SWR decode only when UNALIGNED_STORE_EN is defined.
module store_align
    import store_unit_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    output logic        is_store,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic        ades
);

    // Decode the store op and place register bytes on their lanes
    always_comb begin
        is_store = 1'b0;
        wen      = WEN_NONE;
        wdata    = 32'h0;
        ades     = 1'b0;
        case (aluop)
            ALU_SB: begin
                is_store = 1'b1;
                wen      = WEN_B0 << a;
                wdata    = {4{rt[7:0]}};
            end
            ALU_SH: begin
                is_store = 1'b1;
                ades     = a[0];
                wen      = a[1] ? WEN_HI : WEN_LO;
                wdata    = {2{rt[15:0]}};
            end
            ALU_SW, ALU_SC: begin
                is_store = 1'b1;
                ades     = |a;
                wen      = WEN_ALL;
                wdata    = rt;
            end
`ifdef UNALIGNED_STORE_EN
            ALU_SWL: begin
                is_store = 1'b1;
                case (a)
                    2'b00: begin wen = WEN_B0;  wdata = {24'b0, rt[31:24]}; end
                    2'b01: begin wen = WEN_LO;  wdata = {16'b0, rt[31:16]}; end
                    2'b10: begin wen = WEN_LO3; wdata = {8'b0, rt[31:8]};   end
                    2'b11: begin wen = WEN_ALL; wdata = rt;                 end
                endcase
            end
            ALU_SWR: begin
                is_store = 1'b1;
                case (a)
                    2'b00: begin wen = WEN_ALL; wdata = rt;                 end
                    2'b01: begin wen = WEN_HI3; wdata = {rt[23:0], 8'b0};   end
                    2'b10: begin wen = WEN_HI;  wdata = {rt[15:0], 16'b0};  end
                    2'b11: begin wen = WEN_B3;  wdata = {rt[7:0], 24'b0};   end
                endcase
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: aligns store data and runs the bus handshake,
// stalling until ack. SWL/SWR enabled by UNALIGNED_STORE_EN.
module store_unit
    import store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  aluop_t      aluop,
    input  logic [31:0] vaddr,
    input  logic [31:0] rtdata,
    input  logic        llbit,
    input  logic        flush,
    output logic        stallreq,
    output logic        st_done,
    output logic [31:0] sc_result,
    output logic        excp_ades,
    output logic        bus_en,
    output logic [3:0]  bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok
);

    st_state_e   state_q, state_d;
    logic        bus_en_q, bus_en_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        sc_q, sc_d;

    logic        al_is_st;
    logic [3:0]  al_wen;
    logic [31:0] al_wdata;
    logic        al_ades;
    logic        is_sc;
    logic        st_req;
    logic        start;

    store_align u_align (
        .aluop    (aluop),
        .a        (vaddr[1:0]),
        .rt       (rtdata),
        .is_store (al_is_st),
        .wen      (al_wen),
        .wdata    (al_wdata),
        .ades     (al_ades)
    );

    assign is_sc  = (aluop == ALU_SC);
    assign st_req = st_valid & al_is_st;
    assign start  = st_req & ~al_ades & ~(is_sc & ~llbit) & ~flush;

    // State and bus registers; bus fields only reload on a start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bus_en_q <= 1'b0;
            wen_q    <= 4'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            sc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bus_en_q <= bus_en_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sc_q     <= sc_d;
        end
    end

    // Next-state logic and combinational pipeline/exception outputs
    always_comb begin
        state_d   = state_q;
        bus_en_d  = bus_en_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sc_d      = sc_q;
        stallreq  = 1'b0;
        st_done   = 1'b0;
        sc_result = 32'h0;
        excp_ades = 1'b0;
        case (state_q)
            ST_IDLE: begin
                excp_ades = st_req & al_ades;
                if (start) begin
                    state_d  = ST_ADDR;
                    bus_en_d = 1'b1;
                    wen_d    = al_wen;
                    addr_d   = {vaddr[31:2], 2'b00};
                    wdata_d  = al_wdata;
                    sc_d     = is_sc;
                    stallreq = 1'b1;
                end
            end
            ST_ADDR: begin
                stallreq = 1'b1;
                if (bus_addr_ok) begin
                    bus_en_d = 1'b0;
                    state_d  = bus_data_ok ? ST_DONE : ST_DATA;
                end else if (flush) begin
                    bus_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_DATA: begin
                stallreq = 1'b1;
                if (bus_data_ok) state_d = ST_DONE;
            end
            ST_DONE: begin
                st_done   = 1'b1;
                sc_result = {31'b0, sc_q};
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_en    = bus_en_q;
    assign bus_wen   = wen_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed-vector bench for store_unit: lane mapping, AdES, SC,
// flush in ADDR, reset mid-transaction.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    aluop_t      aluop;
    logic [31:0] vaddr;
    logic [31:0] rtdata;
    logic        llbit;
    logic        flush;
    logic        stallreq;
    logic        st_done;
    logic [31:0] sc_result;
    logic        excp_ades;
    logic        bus_en;
    logic [3:0]  bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;

    int n_vec = 0;
    int n_err = 0;

    store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .aluop       (aluop),
        .vaddr       (vaddr),
        .rtdata      (rtdata),
        .llbit       (llbit),
        .flush       (flush),
        .stallreq    (stallreq),
        .st_done     (st_done),
        .sc_result   (sc_result),
        .excp_ades   (excp_ades),
        .bus_en      (bus_en),
        .bus_wen     (bus_wen),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".bus_en"},  32'(bus_en), 32'h0);
        check({tag, ".wen"},     32'(bus_wen), 32'h0);
        check({tag, ".addr"},    bus_addr, 32'h0);
        check({tag, ".wdata"},   bus_wdata, 32'h0);
        check({tag, ".done"},    32'(st_done), 32'h0);
        check({tag, ".sc"},      sc_result, 32'h0);
        check({tag, ".stall"},   32'(stallreq), 32'h0);
        check({tag, ".ades"},    32'(excp_ades), 32'h0);
    endtask

    // Full store with immediate addr_ok+data_ok in ADDR
    task automatic run_store(input string tag, input aluop_t op,
                             input logic [31:0] va, input logic [31:0] rt,
                             input logic ll, input logic [3:0] ewen,
                             input logic [31:0] ewdata);
        st_valid = 1'b1; aluop = op; vaddr = va; rtdata = rt; llbit = ll;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; flush = 1'b0;
        #1;
        check({tag, ".stall0"}, 32'(stallreq), 32'h1);
        check({tag, ".en0"},    32'(bus_en), 32'h0);
        step();
        check({tag, ".en1"},    32'(bus_en), 32'h1);
        check({tag, ".addr"},   bus_addr, {va[31:2], 2'b00});
        check({tag, ".wen"},    32'(bus_wen), 32'(ewen));
        check({tag, ".wdata"},  bus_wdata, ewdata);
        step();
        check({tag, ".done"},   32'(st_done), 32'h1);
        check({tag, ".stall2"}, 32'(stallreq), 32'h0);
        check({tag, ".sc"},     sc_result, (op == ALU_SC) ? 32'h1 : 32'h0);
        st_valid = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        step();
        check({tag, ".idle"},   32'(st_done), 32'h0);
    endtask

    // Op that must produce neither bus request, stall nor store
    task automatic no_bus(input string tag, input aluop_t op,
                          input logic [31:0] va, input logic [31:0] rt,
                          input logic ll, input logic exp_ades);
        st_valid = 1'b1; aluop = op; vaddr = va; rtdata = rt; llbit = ll;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #1;
        check({tag, ".ades"},  32'(excp_ades), 32'(exp_ades));
        check({tag, ".stall"}, 32'(stallreq), 32'h0);
        check({tag, ".sc"},    sc_result, 32'h0);
        step();
        check({tag, ".en"},    32'(bus_en), 32'h0);
        check({tag, ".done"},  32'(st_done), 32'h0);
        st_valid = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    endtask

    initial begin
        int  stalls;
        bit  got_done;

        rst = 1'b1; st_valid = 1'b0; aluop = '0; vaddr = '0; rtdata = '0;
        llbit = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        step();
        step();
        check_reset("rst");
        rst = 1'b0;
        step();

        run_store("sb3", ALU_SB, 32'h1003, 32'hAABBCC5A, 1'b0,
                  4'b1000, 32'h5A5A5A5A);
        run_store("sb1", ALU_SB, 32'h1001, 32'h000000C3, 1'b0,
                  4'b0010, 32'hC3C3C3C3);
        run_store("sh2", ALU_SH, 32'h2002, 32'h1234BEEF, 1'b0,
                  4'b1100, 32'hBEEFBEEF);
        run_store("sw",  ALU_SW, 32'h2000, 32'hCAFEF00D, 1'b0,
                  4'b1111, 32'hCAFEF00D);

        no_bus("sh_ades", ALU_SH, 32'h2001, 32'h1, 1'b0, 1'b1);
        no_bus("sw_ades", ALU_SW, 32'h2002, 32'h1, 1'b0, 1'b1);
        no_bus("sc_fail", ALU_SC, 32'h2004, 32'h1, 1'b0, 1'b0);

`ifdef UNALIGNED_STORE_EN
        run_store("swr2", ALU_SWR, 32'h3002, 32'h11223344, 1'b0,
                  4'b1100, 32'h33440000);
        run_store("swl1", ALU_SWL, 32'h3001, 32'h11223344, 1'b0,
                  4'b0011, 32'h00001122);
`else
        no_bus("swr_off", ALU_SWR, 32'h3002, 32'h11223344, 1'b0, 1'b0);
        no_bus("swl_off", ALU_SWL, 32'h3001, 32'h11223344, 1'b0, 1'b0);
`endif

        // SC success with data_ok delayed; flush in DATA must be ignored
        st_valid = 1'b1; aluop = ALU_SC; vaddr = 32'h4000;
        rtdata = 32'h0000_0001; llbit = 1'b1;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; flush = 1'b0;
        stalls = 0; got_done = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (stallreq) stalls++;
            if (st_done) begin
                got_done = 1'b1;
                check("sc_ok.sc", sc_result, 32'h1);
                break;
            end
            step();
            bus_addr_ok = (c + 1 == 1);
            flush       = (c + 1 == 2);
            bus_data_ok = (c + 1 == 3);
            #1;
        end
        check("sc_ok.done", 32'(got_done), 32'h1);
        check("sc_ok.stalls", 32'(stalls), 32'd4);
        st_valid = 1'b0; flush = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        step();

        // SW with addr_ok withheld, stray data_ok, then flush in ADDR
        st_valid = 1'b1; aluop = ALU_SW; vaddr = 32'h5000;
        rtdata = 32'hDEADBEEF; llbit = 1'b0;
        #1;
        check("fl.stall0", 32'(stallreq), 32'h1);
        step();
        bus_data_ok = 1'b1;
        #1;
        check("fl.en1", 32'(bus_en), 32'h1);
        step();
        check("fl.en2", 32'(bus_en), 32'h1);
        check("fl.done2", 32'(st_done), 32'h0);
        bus_data_ok = 1'b0; flush = 1'b1; st_valid = 1'b0;
        step();
        flush = 1'b0;
        #1;
        check("fl.en3", 32'(bus_en), 32'h0);
        check("fl.stall3", 32'(stallreq), 32'h0);
        check("fl.done3", 32'(st_done), 32'h0);
        step();
        check("fl.done4", 32'(st_done), 32'h0);

        // Reset while in DATA, then a normal SW
        st_valid = 1'b1; aluop = ALU_SW; vaddr = 32'h6000;
        rtdata = 32'h12345678; bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
        step();
        step();
        check("rd.en", 32'(bus_en), 32'h0);
        check("rd.stall", 32'(stallreq), 32'h1);
        rst = 1'b1; st_valid = 1'b0; bus_addr_ok = 1'b0;
        step();
        check_reset("rd");
        rst = 1'b0;
        step();
        run_store("sw_after", ALU_SW, 32'h7004, 32'h0BADF00D, 1'b0,
                  4'b1111, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
